// File: rtl/keypad_entry_ctrl.sv
// Keypad digit accumulator: builds a multi-digit decimal value, range-checks it and
// offers it on valid/ready. Define KEYPAD_TIMEOUT_EN to abort idle entries on inactivity.
module keypad_entry_ctrl #(
  parameter int NUM_DIGITS     = 3,
  parameter int VAL_W          = 10,
  parameter int MAX_VALUE      = 999,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int TMO_W          = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       key_code,
  input  logic             key_strobe,
  output logic [VAL_W-1:0] cfg_value,
  output logic             cfg_valid,
  input  logic             cfg_ready,
  output logic             entry_busy,
  output logic [2:0]       digit_count,
  output logic             err,
  output logic             key_dropped
);

  // state   | meaning
  // IDLE    | waiting for the first digit of an entry
  // COLLECT | accumulating digits, inactivity timer running
  // CHECK   | one cycle range check of the assembled value
  // OFFER   | cfg_value presented until cfg_ready
  // ERROR   | one cycle err pulse, entry discarded
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_CHECK   = 3'd2,
    S_OFFER   = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  localparam int               ACC_W    = VAL_W + 4;
  localparam logic [2:0]       LAST_CNT = 3'(NUM_DIGITS);
  localparam logic [VAL_W-1:0] MAX_V    = VAL_W'(MAX_VALUE);

  state_t           state_q, state_d;
  logic [VAL_W-1:0] acc_q, acc_d;
  logic [VAL_W-1:0] cfg_value_q, cfg_value_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             key_dropped_q, key_dropped_d;

  logic             is_digit;
  logic [ACC_W-1:0] acc_calc;
  logic [2:0]       cnt_inc;
  logic             tmo_hit;

  assign is_digit = (key_code <= 4'd9);
  // Wide intermediate so acc*10+digit cannot wrap before truncation to VAL_W.
  assign acc_calc = ({4'd0, acc_q} * ACC_W'(10)) + {{VAL_W{1'b0}}, key_code};
  assign cnt_inc  = cnt_q + 3'd1;

`ifdef KEYPAD_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign tmo_hit = (tmo_q == TMO_LAST);

  // Counter only runs through silent COLLECT cycles; any strobe or other state zeroes it.
  always_comb begin
    tmo_d = '0;
    if (state_q == S_COLLECT && !key_strobe) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    cfg_value_d   = cfg_value_q;
    key_dropped_d = key_strobe && (state_q == S_CHECK || state_q == S_OFFER);
    case (state_q)
      S_IDLE: begin
        if (key_strobe && is_digit) begin
          acc_d   = VAL_W'(key_code);
          cnt_d   = 3'd1;
          state_d = (LAST_CNT == 3'd1) ? S_CHECK : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (key_strobe) begin
          if (is_digit) begin
            acc_d = acc_calc[VAL_W-1:0];
            cnt_d = cnt_inc;
            if (cnt_inc == LAST_CNT) begin
              state_d = S_CHECK;
            end
          end
        end else if (tmo_hit) begin
          state_d = S_ERROR;
        end
      end
      S_CHECK: begin
        if (acc_q <= MAX_V) begin
          cfg_value_d = acc_q;
          state_d     = S_OFFER;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_OFFER: begin
        if (cfg_ready) begin
          acc_d   = '0;
          cnt_d   = 3'd0;
          state_d = S_IDLE;
        end
      end
      S_ERROR: begin
        acc_d   = '0;
        cnt_d   = 3'd0;
        state_d = S_IDLE;
      end
      default: begin
        acc_d   = '0;
        cnt_d   = 3'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      cnt_q         <= 3'd0;
      cfg_value_q   <= '0;
      key_dropped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      cfg_value_q   <= cfg_value_d;
      key_dropped_q <= key_dropped_d;
    end
  end

  assign cfg_value   = cfg_value_q;
  assign cfg_valid   = (state_q == S_OFFER);
  assign entry_busy  = (state_q == S_COLLECT) || (state_q == S_CHECK) || (state_q == S_OFFER);
  assign digit_count = cnt_q;
  assign err         = (state_q == S_ERROR);
  assign key_dropped = key_dropped_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Scoreboard bench for keypad_entry_ctrl: driver queues expected outcomes, a negedge
// monitor compares whenever the DUT offers a value or pulses err.
module tb_keypad_entry_ctrl;

  localparam int NUM_DIGITS = 3;
  localparam int VAL_W      = 10;
  localparam int MAX_VALUE  = 700;
  localparam int TMO_CYC    = 16;
  localparam int TMO_W      = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       key_code = 4'd0;
  logic             key_strobe = 1'b0;
  logic             cfg_ready = 1'b0;
  logic [VAL_W-1:0] cfg_value;
  logic             cfg_valid;
  logic             entry_busy;
  logic [2:0]       digit_count;
  logic             err;
  logic             key_dropped;

  keypad_entry_ctrl #(
    .NUM_DIGITS(NUM_DIGITS),
    .VAL_W(VAL_W),
    .MAX_VALUE(MAX_VALUE),
    .TIMEOUT_CYCLES(TMO_CYC),
    .TMO_W(TMO_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_code(key_code),
    .key_strobe(key_strobe),
    .cfg_value(cfg_value),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .entry_busy(entry_busy),
    .digit_count(digit_count),
    .err(err),
    .key_dropped(key_dropped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_err;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int exp_drops = 0;
  int obs_drops = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_key(input logic [3:0] code);
    key_code   = code;
    key_strobe = 1'b1;
    tick();
    key_strobe = 1'b0;
  endtask

  task automatic stray_strobe();
    key_code   = 4'($urandom_range(15, 0));
    key_strobe = 1'b1;
    exp_drops++;
  endtask

  function automatic int model_value(input int d[3]);
    int v = 0;
    foreach (d[i]) v = v * 10 + d[i];
    return v;
  endfunction

  task automatic check_reset_outputs();
    check("rst_cfg_value", cfg_value, 0);
    check("rst_cfg_valid", cfg_valid, 0);
    check("rst_entry_busy", entry_busy, 0);
    check("rst_digit_count", digit_count, 0);
    check("rst_err", err, 0);
    check("rst_key_dropped", key_dropped, 0);
  endtask

  task automatic run_entry(input int d0, input int d1, input int d2,
                           input int gap_lo, input int gap_hi,
                           input bit nd_ins, input bit chk_drop,
                           input int hold, input int drops, input bit hs_strobe);
    int   d[3];
    int   v;
    exp_t e;
    d = '{d0, d1, d2};
    v = model_value(d);
    e.is_err = (v > MAX_VALUE);
    e.val    = v;
    exp_q.push_back(e);
    for (int i = 0; i < 3; i++) begin
      idle($urandom_range(gap_hi, gap_lo));
      send_key(4'(d[i]));
      check("digit_count", digit_count, i + 1);
      check("entry_busy", entry_busy, 1);
      if (nd_ins && i == 0) begin
        send_key(4'($urandom_range(15, 10)));
        check("count_after_nondigit", digit_count, 1);
      end
    end
    check("valid_in_check", cfg_valid, 0);
    check("err_in_check", err, 0);
    if (chk_drop) stray_strobe();
    tick();
    key_strobe = 1'b0;
    if (chk_drop) check("drop_in_check", key_dropped, 1);
    if (e.is_err) begin
      check("err_latency", err, 1);
      check("valid_on_reject", cfg_valid, 0);
      tick();
      check("err_one_cycle", err, 0);
      check("busy_after_err", entry_busy, 0);
      check("count_after_err", digit_count, 0);
    end else begin
      check("valid_latency", cfg_valid, 1);
      for (int k = 0; k < hold; k++) begin
        if (k < drops) stray_strobe();
        tick();
        key_strobe = 1'b0;
        check("valid_held", cfg_valid, 1);
      end
      cfg_ready = 1'b1;
      if (hs_strobe) stray_strobe();
      tick();
      key_strobe = 1'b0;
      cfg_ready  = 1'b0;
      check("valid_after_hs", cfg_valid, 0);
      check("busy_after_hs", entry_busy, 0);
      check("count_after_hs", digit_count, 0);
      if (hs_strobe) check("drop_at_hs", key_dropped, 1);
    end
  endtask

  always @(negedge clk) begin
    exp_t m;
    if (rst_n) begin
      if (key_dropped) obs_drops++;
      if (cfg_valid || err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {err, cfg_valid}, 0);
        end else begin
          m = exp_q[0];
          check("outcome_kind", {err, cfg_valid}, m.is_err ? 2 : 1);
          if (cfg_valid) check("cfg_value", cfg_value, m.val);
          if (err || cfg_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    exp_t e;
    rst_n = 1'b0;
    idle(3);
    check_reset_outputs();
    rst_n = 1'b1;
    tick();

    run_entry(1, 2, 3, 5, 5, 1'b0, 1'b0, 0, 0, 1'b0);
    run_entry(3, 0, 0, 1, 2, 1'b0, 1'b0, 1, 0, 1'b0);
    run_entry(8, 0, 0, 1, 2, 1'b0, 1'b0, 0, 0, 1'b0);
    run_entry(7, 0, 0, 0, 1, 1'b0, 1'b0, 0, 0, 1'b0);
    run_entry(7, 0, 1, 0, 1, 1'b0, 1'b0, 0, 0, 1'b0);
    run_entry(4, 5, 6, 1, 3, 1'b0, 1'b0, 20, 1, 1'b0);

    send_key(4'hF);
    check("busy_after_idle_nondigit", entry_busy, 0);
    check("count_after_idle_nondigit", digit_count, 0);
    run_entry(9, 1, 2, 1, 2, 1'b1, 1'b1, 0, 0, 1'b0);

    run_entry(2, 4, 6, 1, 2, 1'b0, 1'b1, 2, 0, 1'b1);
    run_entry(5, 5, 5, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0);

    cfg_ready = 1'b1;
    idle(3);
    check("ready_idle_valid", cfg_valid, 0);
    check("ready_idle_busy", entry_busy, 0);
    cfg_ready = 1'b0;

    send_key(4'd1);
    send_key(4'd2);
    check("count_before_reset", digit_count, 2);
    rst_n = 1'b0;
    idle(2);
    check_reset_outputs();
    rst_n = 1'b1;
    tick();
    run_entry(0, 0, 7, 1, 2, 1'b0, 1'b0, 0, 0, 1'b0);

`ifdef KEYPAD_TIMEOUT_EN
    e.is_err = 1'b1;
    e.val    = 0;
    exp_q.push_back(e);
    send_key(4'd8);
    check("tmo_first_count", digit_count, 1);
    idle(TMO_CYC - 1);
    check("err_before_tmo", err, 0);
    check("busy_before_tmo", entry_busy, 1);
    tick();
    check("err_at_tmo", err, 1);
    tick();
    check("err_after_tmo", err, 0);
    check("busy_after_tmo", entry_busy, 0);
    run_entry(2, 3, 4, 0, 2, 1'b0, 1'b0, 0, 0, 1'b0);

    e.is_err = 1'b0;
    e.val    = 123;
    exp_q.push_back(e);
    send_key(4'd1);
    idle(TMO_CYC - 1);
    send_key(4'd2);
    check("count_tc_strobe", digit_count, 2);
    check("err_tc_strobe", err, 0);
    cfg_ready = 1'b1;
    send_key(4'd3);
    check("valid_in_check_ready", cfg_valid, 0);
    tick();
    check("valid_tc_entry", cfg_valid, 1);
    tick();
    cfg_ready = 1'b0;
    check("valid_after_tc_hs", cfg_valid, 0);
    check("busy_after_tc_hs", entry_busy, 0);
`endif

    for (int n = 0; n < 50; n++) begin
      int h;
      h = $urandom_range(6, 0);
      run_entry($urandom_range(9, 0), $urandom_range(9, 0), $urandom_range(9, 0),
                0, 4, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                h, $urandom_range(h, 0), 1'($urandom_range(1, 0)));
    end

    idle(5);
    check("scoreboard_drained", exp_q.size(), 0);
    check("key_dropped_count", obs_drops, exp_drops);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
